// File: rtl/reset_sequencer.sv
// reset_sequencer
// ---------------
// Generates NumDomains active-low resets that are released one after another,
// starting from bit 0. Three sources put the block back into reset:
//   - power-on via the asynchronous rst_ni,
//   - the external ext_rst_ni (synchronised, then debounced),
//   - the one-cycle software request sw_rst_req_i.
// It also records the cause of the last reset.
//
// Ports
//   clk_i          : single clock for the whole block
//   rst_ni         : asynchronous active-low power-on reset
//   ext_rst_ni     : asynchronous active-low external reset request
//   sw_rst_req_i   : synchronous one-cycle software reset request
//   domain_rst_no  : registered active-low domain resets, bit 0 released first
//   rst_cause_o    : 2'b00 POR, 2'b01 external, 2'b10 software
//   busy_o         : high while any domain is still held in reset
module reset_sequencer #(
    parameter int NumDomains     = 3,
    parameter int PorCycles      = 200,
    parameter int GapCycles      = 16,
    parameter int HoldCycles     = 32,
    parameter int DebounceCycles = 1024,
    parameter int SyncStages     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ext_rst_ni,
    input  logic                  sw_rst_req_i,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic [1:0]            rst_cause_o,
    output logic                  busy_o
);

    localparam int MaxPg     = (PorCycles > GapCycles) ? PorCycles : GapCycles;
    localparam int MaxCycles = (MaxPg > HoldCycles) ? MaxPg : HoldCycles;
    localparam int CntW      = $clog2(MaxCycles + 1);
    localparam int IdxW      = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam int DebW      = $clog2(DebounceCycles + 1);

    // The counter is loaded with N-1 so that the action happens on the N-th edge.
    localparam logic [CntW-1:0] PorLoad  = CntW'(PorCycles - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'(GapCycles - 1);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HoldCycles - 1);
    localparam logic [DebW-1:0] DebLast  = DebW'(DebounceCycles - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumDomains - 1);

    localparam logic [1:0] CausePor = 2'b00;
    localparam logic [1:0] CauseExt = 2'b01;
    localparam logic [1:0] CauseSw  = 2'b10;

    typedef enum logic [1:0] {
        S_POR,
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_e;

    // ------------------------------------------------------------------
    // External reset synchroniser
    // ------------------------------------------------------------------
    logic [SyncStages-1:0] r_sync;
    logic                  w_ext_sync;

    genvar gi;
    generate
        for (gi = 0; gi < SyncStages; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) r_sync[gi] <= 1'b1;
                    else         r_sync[gi] <= ext_rst_ni;
                end
            end else begin : g_rest
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) r_sync[gi] <= 1'b1;
                    else         r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_ext_sync = r_sync[SyncStages-1];

    // ------------------------------------------------------------------
    // Debounce: the filtered level follows the synchronised input only
    // after DebounceCycles consecutive cycles of disagreement.
    // ------------------------------------------------------------------
    logic            r_ext_filt;
    logic [DebW-1:0] r_deb_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ext_filt <= 1'b1;
            r_deb_cnt  <= '0;
        end else if (w_ext_sync == r_ext_filt) begin
            r_deb_cnt  <= '0;
        end else if (r_deb_cnt == DebLast) begin
            r_ext_filt <= w_ext_sync;
            r_deb_cnt  <= '0;
        end else begin
            r_deb_cnt  <= r_deb_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_e                r_state, w_state_next;
    logic [CntW-1:0]       r_cnt, w_cnt_next;
    logic [IdxW-1:0]       r_idx, w_idx_next;
    logic [NumDomains-1:0] r_dom, w_dom_next;
    logic                  r_busy, w_busy_next;
    logic [1:0]            r_cause, w_cause_next;
    logic                  w_ext_req, w_any_req, w_enter_hold, w_start_rel;

    assign w_ext_req = ~r_ext_filt;
    assign w_any_req = w_ext_req | sw_rst_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_POR;
            r_cnt   <= PorLoad;
            r_idx   <= '0;
            r_dom   <= '0;
            r_busy  <= 1'b1;
            r_cause <= CausePor;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_dom   <= w_dom_next;
            r_busy  <= w_busy_next;
            r_cause <= w_cause_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_dom_next   = r_dom;
        w_busy_next  = r_busy;
        w_cause_next = r_cause;
        w_enter_hold = 1'b0;
        w_start_rel  = 1'b0;

        case (r_state)
            // Requests are deliberately ignored until the power-on count ends.
            S_POR: begin
                if (r_cnt == '0) w_start_rel = 1'b1;
                else             w_cnt_next  = r_cnt - 1'b1;
            end
            // The hold timer only runs while the external reset is inactive;
            // any fresh request restarts the full hold time.
            S_HOLD: begin
                if (w_ext_req) begin
                    w_cnt_next = HoldLoad;
                end else if (sw_rst_req_i) begin
                    w_cnt_next   = HoldLoad;
                    w_cause_next = CauseSw;
                end else if (r_cnt == '0) begin
                    w_start_rel = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_RELEASE: begin
                if (w_any_req) begin
                    w_enter_hold = 1'b1;
                end else if (r_cnt == '0) begin
                    w_dom_next = r_dom | (NumDomains'(1) << r_idx);
                    if (r_idx == LastIdx) begin
                        w_state_next = S_RUN;
                        w_busy_next  = 1'b0;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                        w_cnt_next = GapLoad;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_RUN: begin
                if (w_any_req) w_enter_hold = 1'b1;
            end
            default: w_state_next = S_POR;
        endcase

        // Release of domain 0 always restarts the sequence from the beginning.
        if (w_start_rel) begin
            w_dom_next = NumDomains'(1);
            if (NumDomains == 1) begin
                w_state_next = S_RUN;
                w_busy_next  = 1'b0;
            end else begin
                w_state_next = S_RELEASE;
                w_idx_next   = IdxW'(1);
                w_cnt_next   = GapLoad;
            end
        end

        // External wins over software when both arrive together.
        if (w_enter_hold) begin
            w_state_next = S_HOLD;
            w_dom_next   = '0;
            w_busy_next  = 1'b1;
            w_cnt_next   = HoldLoad;
            w_cause_next = w_ext_req ? CauseExt : CauseSw;
        end
    end

    assign domain_rst_no = r_dom;
    assign rst_cause_o   = r_cause;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: expected output records are queued with the
// absolute clock-edge number at which they must hold, and a monitor compares
// them on the falling edge after that clock edge.
module tb_reset_sequencer;

    localparam int ND   = 3;
    localparam int POR  = 200;
    localparam int GAP  = 16;
    localparam int HOLD = 32;
    localparam int DEB  = 8;
    localparam int SYNC = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ext_n = 1'b1;
    logic          sw    = 1'b0;
    logic [ND-1:0] dom;
    logic [1:0]    cause;
    logic          busy;

    reset_sequencer #(
        .NumDomains    (ND),
        .PorCycles     (POR),
        .GapCycles     (GAP),
        .HoldCycles    (HOLD),
        .DebounceCycles(DEB),
        .SyncStages    (SYNC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ext_rst_ni   (ext_n),
        .sw_rst_req_i (sw),
        .domain_rst_no(dom),
        .rst_cause_o  (cause),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int            edge_no;
        logic [ND-1:0] dom;
        logic          busy;
        logic [1:0]    cause;
        string         name;
    } exp_t;

    typedef struct {
        int            offset;
        logic [ND-1:0] dom;
        logic          busy;
    } rel_vec_t;

    exp_t     sb[$];
    rel_vec_t rel_tab[6];
    int       checks = 0;
    int       errors = 0;

    task automatic check_now(input string name, input logic [ND-1:0] edom,
                             input logic ebusy, input logic [1:0] ecause);
        checks++;
        if (dom !== edom || busy !== ebusy || cause !== ecause) begin
            errors++;
            $display("FAIL %s @edge %0d: got dom=%b busy=%b cause=%b, want dom=%b busy=%b cause=%b",
                     name, edge_cnt, dom, busy, cause, edom, ebusy, ecause);
        end else begin
            $display("ok   %s @edge %0d: dom=%b busy=%b cause=%b", name, edge_cnt, dom, busy, cause);
        end
    endtask

    task automatic expect_at(input int e, input logic [ND-1:0] d, input logic b,
                             input logic [1:0] c, input string n);
        exp_t x;
        x.edge_no = e;
        x.dom     = d;
        x.busy    = b;
        x.cause   = c;
        x.name    = n;
        sb.push_back(x);
    endtask

    // base = edge on which bit 0 rises
    task automatic push_release(input int base, input logic [1:0] c, input string n);
        for (int i = 0; i < 6; i++)
            expect_at(base + rel_tab[i].offset, rel_tab[i].dom, rel_tab[i].busy, c, n);
    endtask

    task automatic goto_edge(input int t);
        while (edge_cnt < t) @(negedge clk);
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (sb.size() > 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d expectations left, first %s at edge %0d, now %0d",
                     sb.size(), sb[0].name, sb[0].edge_no, edge_cnt);
            sb.delete();
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            if (sb[0].edge_no == edge_cnt) begin
                check_now(sb[0].name, sb[0].dom, sb[0].busy, sb[0].cause);
            end else begin
                checks++;
                errors++;
                $display("FAIL %s missed: due edge %0d, now %0d", sb[0].name, sb[0].edge_no, edge_cnt);
            end
            void'(sb.pop_front());
        end
    end

    initial begin
        int e;
        int b;

        rel_tab[0] = '{-1,        3'b000, 1'b1};
        rel_tab[1] = '{0,         3'b001, 1'b1};
        rel_tab[2] = '{GAP - 1,   3'b001, 1'b1};
        rel_tab[3] = '{GAP,       3'b011, 1'b1};
        rel_tab[4] = '{2*GAP - 1, 3'b011, 1'b1};
        rel_tab[5] = '{2*GAP,     3'b111, 1'b0};

        // Reset state and power-on release
        repeat (3) @(negedge clk);
        check_now("por_reset_state", 3'b000, 1'b1, 2'b00);
        e = edge_cnt;
        rst_n = 1'b1;
        push_release(e + POR, 2'b00, "power_on");
        drain(400);

        // 5-cycle external glitch: rejected
        @(negedge clk);
        e = edge_cnt;
        ext_n = 1'b0;
        expect_at(e + 5,  3'b111, 1'b0, 2'b00, "glitch");
        expect_at(e + 11, 3'b111, 1'b0, 2'b00, "glitch");
        expect_at(e + 20, 3'b111, 1'b0, 2'b00, "glitch");
        goto_edge(e + 5);
        ext_n = 1'b1;
        drain(100);

        // 40-cycle external low: reset after SYNC+DEB+1 edges, hold after filter rises
        @(negedge clk);
        e = edge_cnt;
        ext_n = 1'b0;
        expect_at(e + 10, 3'b111, 1'b0, 2'b00, "ext_pre");
        expect_at(e + 11, 3'b000, 1'b1, 2'b01, "ext_assert");
        expect_at(e + 50, 3'b000, 1'b1, 2'b01, "ext_hold");
        push_release(e + 50 + HOLD, 2'b01, "ext_release");
        goto_edge(e + 40);
        ext_n = 1'b1;
        drain(200);

        // Software reset
        @(negedge clk);
        e = edge_cnt;
        sw = 1'b1;
        expect_at(e + 1, 3'b000, 1'b1, 2'b10, "sw_assert");
        push_release(e + 1 + HOLD, 2'b10, "sw_release");
        @(negedge clk);
        sw = 1'b0;
        drain(200);

        // Simultaneous external and software, then software reload in HOLD
        @(negedge clk);
        e = edge_cnt;
        ext_n = 1'b0;
        expect_at(e + 10, 3'b111, 1'b0, 2'b10, "simul_pre");
        expect_at(e + 11, 3'b000, 1'b1, 2'b01, "simul_cause_ext");
        expect_at(e + 30, 3'b000, 1'b1, 2'b01, "simul_hold");
        expect_at(e + 31, 3'b000, 1'b1, 2'b10, "hold_sw_cause");
        expect_at(e + 52, 3'b000, 1'b1, 2'b10, "hold_reload_delay");
        push_release(e + 31 + HOLD, 2'b10, "hold_reload_release");
        goto_edge(e + 10);
        ext_n = 1'b1;
        sw    = 1'b1;
        goto_edge(e + 11);
        sw = 1'b0;
        goto_edge(e + 30);
        sw = 1'b1;
        goto_edge(e + 31);
        sw = 1'b0;
        drain(200);

        // Asynchronous reset mid-RUN, then full power-on repeats
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_now("async_assert", 3'b000, 1'b1, 2'b00);
        @(negedge clk);
        e = edge_cnt;
        rst_n = 1'b1;
        push_release(e + POR, 2'b00, "power_on_again");
        drain(400);

        // Software during POR ignored; software right after bit 0 restarts
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        e = edge_cnt;
        rst_n = 1'b1;
        b = e + POR;
        expect_at(e + 51, 3'b000, 1'b1, 2'b00, "por_ignores_sw");
        expect_at(b,      3'b001, 1'b1, 2'b00, "mid_bit0");
        expect_at(b + 1,  3'b001, 1'b1, 2'b00, "mid_bit0_hold");
        expect_at(b + 2,  3'b000, 1'b1, 2'b10, "mid_sw_assert");
        push_release(b + 2 + HOLD, 2'b10, "mid_restart");
        goto_edge(e + 50);
        sw = 1'b1;
        goto_edge(e + 51);
        sw = 1'b0;
        goto_edge(b + 1);
        sw = 1'b1;
        goto_edge(b + 2);
        sw = 1'b0;
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
